stream_packer: RTL

Width-converting consumer for the read side of `fifo`: accepts C_IN_WIDTH words over the fifo's RD_DATA/RD_VALID/RD_READY handshake and packs C_RATIO consecutive words into one wide output beat. Marks every C_BURST_BEATS-th beat with OUT_LAST. If input stalls with a partial beat assembled, flushes that partial beat after C_TIMEOUT idle cycles, with a lane mask. Sits between a `fifo` instance and the wide action datapath/host write path.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/stream_packer_pkg.sv | 10 +
 rtl/sat_counter.sv | 26 ++
 rtl/stream_packer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the fifo family plus an elaboration-time parameter check.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

`define FIFO_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("illegal parameter combination"); \
  end

package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Never returns zero, so a counter for a value range of one still gets a real bit.
  function automatic int unsigned clog2s(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

`endif

// File: rtl/stream_packer_pkg.sv
// Types shared by the packer and its bench-visible state decode.
package stream_packer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH
  } packState_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at LIMIT; one cycle from enable to count.
// No handshake: clear wins over enable.
module sat_counter
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LIMIT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  `FIFO_PARAM_CHECK(gLimitFits, (64'(LIMIT) < (64'd1 << WIDTH)))

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count <= '0;
    end else if (enable && (count != WIDTH'(LIMIT))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/stream_packer.sv
// Packs C_RATIO fifo words into one wide beat (lane 0 at LSBs); beat is valid the cycle after its last word.
// Stalls the fifo only when a completing word meets a held output or a flush is pending; idle partials flush after C_TIMEOUT.
module stream_packer
  import fifo_pkg::*;
  import stream_packer_pkg::*;
#(
  parameter int unsigned C_IN_WIDTH    = 32,
  parameter int unsigned C_RATIO       = 4,
  parameter int unsigned C_BURST_BEATS = 16,
  parameter int unsigned C_TIMEOUT     = 64
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_IN_WIDTH-1:0]         RD_DATA,
  input  logic                          RD_VALID,
  output logic                          RD_READY,
  output logic [C_IN_WIDTH*C_RATIO-1:0] OUT_DATA,
  output logic [C_RATIO-1:0]            OUT_KEEP,
  output logic                          OUT_LAST,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY
);

  localparam int unsigned LANE_W  = clog2s(C_RATIO);
  localparam int unsigned TIMER_W = clog2s(C_TIMEOUT + 1);
  localparam int unsigned BURST_W = clog2s(C_BURST_BEATS);
  localparam int unsigned OUT_W   = C_IN_WIDTH * C_RATIO;

  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(C_RATIO - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT   = TIMER_W'(C_TIMEOUT);
  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(C_BURST_BEATS - 1);

  `FIFO_PARAM_CHECK(gRatioCheck, C_RATIO >= 2)
  `FIFO_PARAM_CHECK(gBurstCheck, C_BURST_BEATS >= 1)
  `FIFO_PARAM_CHECK(gTimeoutCheck, C_TIMEOUT >= 1)

  logic [C_RATIO-2:0][C_IN_WIDTH-1:0] asmLanes;
  logic [LANE_W-1:0]                  lane;
  logic [TIMER_W-1:0]                 idleTimer;
  logic [BURST_W-1:0]                 burstCnt;
  packState_t                         state;
  logic                               outFree;
  logic                               flushPending;
  logic                               flushLoad;
  logic                               wordAccept;
  logic [OUT_W-1:0]                   flushData;
  logic [C_RATIO-1:0]                 flushKeep;

  always_comb begin
    state = IDLE;
    if (lane != '0) begin
      state = (idleTimer == TIMEOUT) ? FLUSH : FILL;
    end
  end

  assign outFree      = !OUT_VALID || OUT_READY;
  assign flushPending = (state == FLUSH);
  assign flushLoad    = flushPending && outFree;
  assign RD_READY     = !RST && !flushPending && !((lane == LAST_LANE) && !outFree);
  assign wordAccept   = RD_VALID && RD_READY;

  sat_counter #(
    .WIDTH (TIMER_W),
    .LIMIT (C_TIMEOUT)
  ) uIdleTimer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (wordAccept || (lane == '0) || flushLoad),
    .enable (1'b1),
    .count  (idleTimer)
  );

  // Lanes at or above the fill point may hold stale words from an earlier beat, so they are zeroed here.
  always_comb begin
    flushData = '0;
    flushKeep = '0;
    for (int i = 0; i < int'(C_RATIO) - 1; i++) begin
      if (i < int'(lane)) begin
        flushKeep[i] = 1'b1;
        flushData[i*C_IN_WIDTH +: C_IN_WIDTH] = asmLanes[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lane      <= '0;
      burstCnt  <= '0;
      asmLanes  <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_KEEP  <= '0;
      OUT_LAST  <= 1'b0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (wordAccept) begin
        if (lane == LAST_LANE) begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= {RD_DATA, asmLanes};
          OUT_KEEP  <= '1;
          OUT_LAST  <= (burstCnt == LAST_BEAT);
          burstCnt  <= (burstCnt == LAST_BEAT) ? '0 : burstCnt + BURST_W'(1);
          lane      <= '0;
        end else begin
          asmLanes[lane] <= RD_DATA;
          lane           <= lane + LANE_W'(1);
        end
      end else if (flushLoad) begin
        // A flushed partial always closes the burst so the host sees a clean boundary.
        OUT_VALID <= 1'b1;
        OUT_DATA  <= flushData;
        OUT_KEEP  <= flushKeep;
        OUT_LAST  <= 1'b1;
        burstCnt  <= '0;
        lane      <= '0;
      end
    end
  end

endmodule
